// File: rtl/fwd_hazard_tracker.sv
// Forwarding and hazard unit: keeps its own shadow pipeline of in-flight destination tags (EX onward)
// and derives EX forward selects, MEM-stage ld/st forwards, load-use stalls and a saturating stall counter.
module fwd_hazard_tracker #(
    parameter int REG_BITS  = 4,
    parameter int NUM_SRC   = 2,
    parameter int FWD_DEPTH = 2,
    parameter int LOAD_LAT  = 1,
    parameter int CNT_BITS  = 16,
    localparam int FSEL_W   = $clog2(FWD_DEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        id_valid,
    input  logic [NUM_SRC*REG_BITS-1:0] id_src,
    input  logic [NUM_SRC-1:0]          id_src_used,
    input  logic [REG_BITS-1:0]         id_rd,
    input  logic                        id_rw,
    input  logic                        id_mr,
    input  logic                        id_mw,
    input  logic                        mem_stall,
    input  logic                        flush,
    output logic                        stall,
    output logic [NUM_SRC*FSEL_W-1:0]   ex_fwd_sel,
    output logic [NUM_SRC-1:0]          mem_fwd,
    output logic [CNT_BITS-1:0]         stall_cnt
);

    // Entry 0 is EX, entry k is the k-th pipeline register after EX.
    logic                        valid_q [FWD_DEPTH+1];
    logic                        rw_q    [FWD_DEPTH+1];
    logic                        mr_q    [FWD_DEPTH+1];
    logic                        mw_q    [FWD_DEPTH+1];
    logic [REG_BITS-1:0]         rd_q    [FWD_DEPTH+1];
    logic [NUM_SRC*REG_BITS-1:0] src_q   [FWD_DEPTH+1];
    logic [NUM_SRC-1:0]          used_q  [FWD_DEPTH+1];
    logic [CNT_BITS-1:0]         cnt_q, cnt_d;

    logic load_use;
    logic ins_d;
    logic early_load_hit;

    always_comb begin
        load_use = 1'b0;
        for (int s = 0; s < NUM_SRC; s++) begin
            for (int j = 0; j < LOAD_LAT; j++) begin
                if (id_valid && id_src_used[s] && valid_q[j] && mr_q[j] && rw_q[j] &&
                    rd_q[j] != '0 && rd_q[j] == id_src[s*REG_BITS +: REG_BITS]) begin
                    load_use = 1'b1;
                end
            end
        end
    end

    assign stall = mem_stall | (load_use & ~flush);
    assign ins_d = id_valid & ~flush & ~load_use;

    // Scanning oldest to youngest lets the youngest producer overwrite the select.
    always_comb begin
        ex_fwd_sel     = '0;
        early_load_hit = 1'b0;
        for (int s = 0; s < NUM_SRC; s++) begin
            for (int k = FWD_DEPTH; k >= 1; k--) begin
                if (valid_q[k] && rw_q[k] && rd_q[k] != '0 && used_q[0][s] &&
                    rd_q[k] == src_q[0][s*REG_BITS +: REG_BITS]) begin
                    ex_fwd_sel[s*FSEL_W +: FSEL_W] = FSEL_W'(k);
                    if (k <= LOAD_LAT && mr_q[k]) early_load_hit = 1'b1;
                end
            end
        end
    end

    generate
        if (FWD_DEPTH >= 2) begin : g_mem_fwd
            always_comb begin
                mem_fwd = '0;
                for (int s = 0; s < NUM_SRC; s++) begin
                    if (valid_q[1] && (mr_q[1] || mw_q[1]) && used_q[1][s] &&
                        valid_q[2] && rw_q[2] && rd_q[2] != '0 &&
                        rd_q[2] == src_q[1][s*REG_BITS +: REG_BITS]) begin
                        mem_fwd[s] = 1'b1;
                    end
                end
            end
        end else begin : g_no_mem_fwd
            assign mem_fwd = '0;
        end
    endgenerate

    always_comb begin
        cnt_d = cnt_q;
        if (stall && cnt_q != '1) cnt_d = cnt_q + CNT_BITS'(1);
    end

    assign stall_cnt = cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k <= FWD_DEPTH; k++) begin
                valid_q[k] <= 1'b0;
                rw_q[k]    <= 1'b0;
                mr_q[k]    <= 1'b0;
                mw_q[k]    <= 1'b0;
                rd_q[k]    <= '0;
                src_q[k]   <= '0;
                used_q[k]  <= '0;
            end
            cnt_q <= '0;
        end else begin
            if (!mem_stall) begin
                for (int k = FWD_DEPTH; k >= 1; k--) begin
                    valid_q[k] <= valid_q[k-1];
                    rw_q[k]    <= rw_q[k-1];
                    mr_q[k]    <= mr_q[k-1];
                    mw_q[k]    <= mw_q[k-1];
                    rd_q[k]    <= rd_q[k-1];
                    src_q[k]   <= src_q[k-1];
                    used_q[k]  <= used_q[k-1];
                end
                // A bubble carries no fields so a killed instruction can never match.
                valid_q[0] <= ins_d;
                rw_q[0]    <= ins_d & id_rw;
                mr_q[0]    <= ins_d & id_mr;
                mw_q[0]    <= ins_d & id_mw;
                rd_q[0]    <= ins_d ? id_rd : '0;
                src_q[0]   <= ins_d ? id_src : '0;
                used_q[0]  <= ins_d ? id_src_used : '0;
            end
            cnt_q <= cnt_d;
        end
    end

    logic unused_ok;
    assign unused_ok = mw_q[0] ^ mw_q[FWD_DEPTH] ^ (^src_q[FWD_DEPTH]) ^ (^used_q[FWD_DEPTH]);

    a_no_early_load: assert property (@(posedge clk) disable iff (rst) !early_load_hit);

endmodule
